// File: rtl/bcd_score_display_if.sv
// Bundle of the score-display signals between the game logic (master) and the
// bcd_score_display block (slave). DIGITS must match the attached block.
interface bcd_score_display_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  clear;
  logic                  enable;
  logic                  score_in;
  logic [4*DIGITS-1:0]   count_bcd;
  logic [7*DIGITS-1:0]   hex;
  logic                  wrap;
  logic                  max_reached;
  logic [4*DIGITS-1:0]   hi_bcd;
  logic [7*DIGITS-1:0]   hi_hex;

  modport master (
    output clear, enable, score_in,
    input  count_bcd, hex, wrap, max_reached, hi_bcd, hi_hex
  );

  modport slave (
    input  clear, enable, score_in,
    output count_bcd, hex, wrap, max_reached, hi_bcd, hi_hex
  );
endinterface

// File: rtl/bcd_score_display.sv
// Multi-digit BCD score counter with synchronised strobe edge detection and
// registered active-low 7-segment outputs. Optional macro: BCD_SCORE_HIGH_SCORE_EN.
module bcd_score_display #(
  parameter int unsigned DIGITS     = 3,
  parameter bit          SAT_AT_MAX = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input logic                clock,
  input logic                reset,
  bcd_score_display_if.slave bus
);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Walk from the top digit down; a digit is blanked while everything above it is zero.
  function automatic logic [7*DIGITS-1:0] display(input logic [4*DIGITS-1:0] v);
    logic [7*DIGITS-1:0] r;
    logic                lz;
    logic [3:0]          d;
    r  = '1;
    lz = 1'b1;
    for (int unsigned k = DIGITS; k > 0; k--) begin
      d  = v[4*(k-1) +: 4];
      lz = lz & (d == 4'd0);
      if (BLANK_LZ && lz && (k != 1))
        r[7*(k-1) +: 7] = '1;
      else
        r[7*(k-1) +: 7] = seg7(d);
    end
    return r;
  endfunction

  function automatic logic all_nines(input logic [4*DIGITS-1:0] v);
    logic n;
    n = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++)
      n = n & (v[4*k +: 4] == 4'd9);
    return n;
  endfunction

  // Digits above 9 are treated as 9 so a corrupted digit still carries and clears.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    logic [3:0]          d;
    r     = v;
    carry = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic                sync1, sync2, prev;
  logic                rise;
  logic [4*DIGITS-1:0] count, count_next;
  logic [7*DIGITS-1:0] hex;
  logic                wrap, wrap_next, max_reached;

  assign rise = sync2 & ~prev;

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (bus.clear) begin
      count_next = '0;
    end else if (rise && bus.enable) begin
      if (all_nines(count)) begin
        if (!SAT_AT_MAX) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        count_next = bcd_inc(count);
      end
    end
  end

  // Sync flops reset high so a strobe held across reset release is not a point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      count       <= '0;
      wrap        <= 1'b0;
      max_reached <= 1'b0;
      hex         <= display('0);
    end else begin
      sync1       <= bus.score_in;
      sync2       <= sync1;
      prev        <= sync2;
      count       <= count_next;
      wrap        <= wrap_next;
      max_reached <= all_nines(count_next);
      hex         <= display(count);
    end
  end

  assign bus.count_bcd   = count;
  assign bus.hex         = hex;
  assign bus.wrap        = wrap;
  assign bus.max_reached = max_reached;

`ifdef BCD_SCORE_HIGH_SCORE_EN
  logic [4*DIGITS-1:0] hi_bcd;
  logic [7*DIGITS-1:0] hi_hex;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_bcd <= '0;
      hi_hex <= display('0);
    end else begin
      if (count > hi_bcd)
        hi_bcd <= count;
      hi_hex <= display(hi_bcd);
    end
  end

  assign bus.hi_bcd = hi_bcd;
  assign bus.hi_hex = hi_hex;
`else
  assign bus.hi_bcd = '0;
  assign bus.hi_hex = display('0);
`endif

endmodule

// File: tb/tb_bcd_score_display.sv
// Directed bench for bcd_score_display: a saturating/blanking instance and a
// wrapping/non-blanking instance driven with identical stimulus.
module tb_bcd_score_display;

`ifdef BCD_SCORE_HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, BL = 7'b1111111;
  localparam logic [20:0] RST_S = {BL, BL, S0};
  localparam logic [20:0] RST_W = {S0, S0, S0};

  logic clock = 1'b0;
  logic reset, clear, enable, score_in;
  int   errors = 0;
  int   checks = 0;
  int   wrap_cnt_s = 0, wrap_cnt_w = 0, wrap_bad = 0;

  always #5 clock = ~clock;

  bcd_score_display_if #(.DIGITS(3)) ifs ();
  bcd_score_display_if #(.DIGITS(3)) ifw ();

  assign ifs.clear    = clear;
  assign ifs.enable   = enable;
  assign ifs.score_in = score_in;
  assign ifw.clear    = clear;
  assign ifw.enable   = enable;
  assign ifw.score_in = score_in;

  bcd_score_display #(.DIGITS(3), .SAT_AT_MAX(1'b1), .BLANK_LZ(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .bus(ifs.slave)
  );
  bcd_score_display #(.DIGITS(3), .SAT_AT_MAX(1'b0), .BLANK_LZ(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .bus(ifw.slave)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (ifs.wrap) wrap_cnt_s++;
      if (ifw.wrap) begin
        wrap_cnt_w++;
        if (ifw.count_bcd != 12'h000) wrap_bad++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic pulses(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      score_in = 1'b1;
      idle(h);
      score_in = 1'b0;
      idle(l);
    end
  endtask

  task automatic check_both_count(input string name, input logic [11:0] exp);
    check({name, "_count_sat"}, 32'(ifs.count_bcd), 32'(exp));
    check({name, "_count_wrap"}, 32'(ifw.count_bcd), 32'(exp));
  endtask

  typedef struct {
    int          pulses;
    logic        en;
    logic [11:0] cnt;
    logic [20:0] hs;
    logic [20:0] hw;
  } vec_t;

  vec_t vt[10];
  int   ws0, ww0;
  bit   seen;

  initial begin
    vt[0] = '{5,   1'b1, 12'h005, {BL, BL, S5}, {S0, S0, S5}};
    vt[1] = '{3,   1'b0, 12'h005, {BL, BL, S5}, {S0, S0, S5}};
    vt[2] = '{4,   1'b1, 12'h009, {BL, BL, S9}, {S0, S0, S9}};
    vt[3] = '{1,   1'b1, 12'h010, {BL, S1, S0}, {S0, S1, S0}};
    vt[4] = '{13,  1'b1, 12'h023, {BL, S2, S3}, {S0, S2, S3}};
    vt[5] = '{64,  1'b1, 12'h087, {BL, S8, S7}, {S0, S8, S7}};
    vt[6] = '{19,  1'b1, 12'h106, {S1, S0, S6}, {S1, S0, S6}};
    vt[7] = '{140, 1'b1, 12'h246, {S2, S4, S6}, {S2, S4, S6}};
    vt[8] = '{112, 1'b1, 12'h358, {S3, S5, S8}, {S3, S5, S8}};
    vt[9] = '{1,   1'b1, 12'h359, {S3, S5, S9}, {S3, S5, S9}};

    // Reset with the strobe already high.
    reset = 1'b1; clear = 1'b0; enable = 1'b1; score_in = 1'b1;
    idle(3);
    check_both_count("rst", 12'h000);
    check("rst_hex_sat", 32'(ifs.hex), 32'(RST_S));
    check("rst_hex_wrap", 32'(ifw.hex), 32'(RST_W));
    check("rst_max", 32'({ifs.max_reached, ifw.max_reached, ifs.wrap, ifw.wrap}), 32'd0);
    check("rst_hi", 32'(ifs.hi_bcd), 32'd0);
    reset = 1'b0;
    idle(8);
    check_both_count("held_high", 12'h000);

    // Fresh edge with exact latency: count at N+2, hex at N+3.
    score_in = 1'b0;
    idle(3);
    score_in = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    check_both_count("lat_n1", 12'h000);
    @(posedge clock); #1;
    check_both_count("lat_n2", 12'h001);
    check("lat_n2_hex", 32'(ifs.hex), 32'(RST_S));
    @(posedge clock); #1;
    check("lat_n3_hex", 32'(ifs.hex), 32'({BL, BL, S1}));
    score_in = 1'b0;
    idle(3);

    // Asynchronous reset clears without a clock edge.
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check_both_count("async_rst", 12'h000);
    check("async_rst_hex", 32'(ifs.hex), 32'(RST_S));
    idle(2);
    reset = 1'b0;
    idle(2);

    foreach (vt[i]) begin
      enable = vt[i].en;
      pulses(vt[i].pulses, 3, 3);
      enable = 1'b1;
      idle(2);
      check($sformatf("vec%0d_count_sat", i), 32'(ifs.count_bcd), 32'(vt[i].cnt));
      check($sformatf("vec%0d_count_wrap", i), 32'(ifw.count_bcd), 32'(vt[i].cnt));
      check($sformatf("vec%0d_hex_sat", i), 32'(ifs.hex), 32'(vt[i].hs));
      check($sformatf("vec%0d_hex_wrap", i), 32'(ifw.hex), 32'(vt[i].hw));
      check($sformatf("vec%0d_flags", i),
            32'({ifs.max_reached, ifw.max_reached, ifs.wrap, ifw.wrap}), 32'd0);
    end

    // clear lands on the same edge as the rise: point lost, high score kept.
    score_in = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check_both_count("clr", 12'h000);
    check("clr_hex_lag", 32'(ifs.hex), 32'({S3, S5, S9}));
    check("clr_hi", 32'(ifs.hi_bcd), HS ? 32'h359 : 32'h0);
    @(posedge clock); #1;
    check("clr_hex_sat", 32'(ifs.hex), 32'(RST_S));
    check("clr_hex_wrap", 32'(ifw.hex), 32'(RST_W));
    idle(2);
    score_in = 1'b0;
    idle(4);
    check_both_count("clr_lost", 12'h000);

    // Saturate vs wrap at all nines.
    ws0 = wrap_cnt_s; ww0 = wrap_cnt_w;
    pulses(999, 2, 2);
    idle(3);
    check_both_count("nines", 12'h999);
    check("nines_max", 32'({ifs.max_reached, ifw.max_reached}), 32'd3);
    check("nines_hex_sat", 32'(ifs.hex), 32'({S9, S9, S9}));
    check("nines_wrap_none", 32'(wrap_cnt_w - ww0), 32'd0);
    pulses(1, 2, 2);
    idle(3);
    check("sat_hold", 32'(ifs.count_bcd), 32'h999);
    check("sat_max", 32'(ifs.max_reached), 32'd1);
    check("sat_wrap_never", 32'(wrap_cnt_s - ws0), 32'd0);
    check("wrap_count", 32'(ifw.count_bcd), 32'h000);
    check("wrap_max_fall", 32'(ifw.max_reached), 32'd0);
    check("wrap_pulse_once", 32'(wrap_cnt_w - ww0), 32'd1);
    check("wrap_with_zero", 32'(wrap_bad), 32'd0);
    check("wrap_hex", 32'(ifw.hex), 32'(RST_W));

    // High score survives clear and lags count by one cycle.
    @(posedge clock); #3;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
    check("hi_after_rst", 32'(ifs.hi_bcd), 32'd0);
    pulses(12, 3, 3);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    pulses(7, 3, 3);
    idle(2);
    check_both_count("hs7", 12'h007);
    check("hs7_hi_sat", 32'(ifs.hi_bcd), HS ? 32'h012 : 32'h0);
    check("hs7_hi_wrap", 32'(ifw.hi_bcd), HS ? 32'h012 : 32'h0);
    check("hs7_hihex", 32'(ifs.hi_hex), HS ? 32'({BL, S1, S2}) : 32'(RST_S));
    pulses(5, 3, 3);
    score_in = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clock); #1;
      if (ifs.count_bcd == 12'h013) seen = 1'b1;
    end
    check("hs13_seen", 32'(seen), 32'd1);
    check("hs13_hi_lag", 32'(ifs.hi_bcd), HS ? 32'h012 : 32'h0);
    @(posedge clock); #1;
    check("hs13_hi", 32'(ifs.hi_bcd), HS ? 32'h013 : 32'h0);
    @(posedge clock); #1;
    check("hs13_hihex_sat", 32'(ifs.hi_hex), HS ? 32'({BL, S1, S3}) : 32'(RST_S));
    check("hs13_hihex_wrap", 32'(ifw.hi_hex), HS ? 32'({S0, S1, S3}) : 32'(RST_W));
    score_in = 1'b0;
    idle(3);
    #2;
    reset = 1'b1;
    #1;
    check("hs_rst_hi", 32'(ifs.hi_bcd), 32'd0);
    check("hs_rst_hihex", 32'(ifs.hi_hex), 32'(RST_S));
    idle(2);
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
